// File: rtl/remote_cmd_seq.sv
// remote_cmd_seq
//   Remote-side command sequencer. It buffers flight commands from the
//   joystick/button logic in a small request FIFO. It issues them one at a
//   time through the RemoteComm send/response handshake, waits for the
//   ACK_VAL byte under a per-command timeout, and reports done/err for each
//   command.
//
//   Optional feature macro: CMD_RETRY_EN
//     defined   - on timeout, resend the same cmd/data up to MAX_RETRY times
//                 before reporting err (err_code 10)
//     undefined - the first timeout reports err (err_code 10) immediately
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   req_vld/req_rdy   host request handshake; push when both are high
//   req_cmd, req_data opcode and payload of the request
//   send_cmd          one-cycle pulse to RemoteComm to start a frame
//   cmd, data         opcode/payload to RemoteComm, stable while in flight
//   cmd_sent          RemoteComm finished transmitting
//   resp_rdy, resp    RemoteComm holds a response byte
//   clr_resp_rdy      one-cycle pulse that consumes the response
//   done              one-cycle pulse: ACK received
//   err, err_code     one-cycle error pulse; code 01 = bad byte, 10 = timeout
//   last_cmd          opcode of the most recently finished command
//   busy              sequencer active or requests pending
module remote_cmd_seq #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TMO_CYCLES     = 1_000_000,
    parameter int unsigned CAL_TMO_CYCLES = 50_000_000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [7:0]  ACK_VAL        = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    input  logic [7:0]  req_cmd,
    input  logic [15:0] req_data,
    output logic        req_rdy,
    output logic        send_cmd,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_resp_rdy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  last_cmd,
    output logic        busy
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam int unsigned TMO_MAX = (TMO_CYCLES > CAL_TMO_CYCLES) ? TMO_CYCLES : CAL_TMO_CYCLES;
    localparam int unsigned TW      = ($clog2(TMO_MAX) < 1) ? 1 : $clog2(TMO_MAX);

    localparam logic [7:0]    SET_CAL  = 8'h06;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TMO_CYCLES - 1);
    localparam logic [TW-1:0] CAL_LOAD = TW'(CAL_TMO_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_SENT,
        WAIT_RESP,
        CHECK
    } state_t;

    state_t state, state_nxt;

    // Request FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [7:0]    fifo_cmd  [FIFO_DEPTH];
    logic [15:0]   fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop;

    logic [TW-1:0] tmo_cnt;
    logic [7:0]    resp_q;

    logic       send_nxt, clr_nxt, done_nxt, err_nxt, tmo_load, resp_cap;
    logic [1:0] err_code_nxt;

`ifdef CMD_RETRY_EN
    localparam int unsigned RW = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_cnt;
    logic          retry_inc;
`endif

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign req_rdy = !full;
    assign push    = req_vld && !full;
    assign busy    = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cmd[wr_ptr[AW-1:0]]  <= req_cmd;
            fifo_data[wr_ptr[AW-1:0]] <= req_data;
        end
    end

    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        send_nxt     = 1'b0;
        clr_nxt      = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        err_code_nxt = 2'b00;
        tmo_load     = 1'b0;
        resp_cap     = 1'b0;
`ifdef CMD_RETRY_EN
        retry_inc    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                send_nxt  = 1'b1;
                state_nxt = WAIT_SENT;
            end
            WAIT_SENT: begin
                if (cmd_sent) begin
                    tmo_load  = 1'b1;
                    state_nxt = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response arriving on the last timeout cycle still counts.
                if (resp_rdy) begin
                    clr_nxt   = 1'b1;
                    resp_cap  = 1'b1;
                    state_nxt = CHECK;
                end else if (tmo_cnt == '0) begin
`ifdef CMD_RETRY_EN
                    if (retry_cnt < RW'(MAX_RETRY)) begin
                        retry_inc = 1'b1;
                        state_nxt = SEND;
                    end else begin
                        err_nxt      = 1'b1;
                        err_code_nxt = 2'b10;
                        state_nxt    = IDLE;
                    end
`else
                    err_nxt      = 1'b1;
                    err_code_nxt = 2'b10;
                    state_nxt    = IDLE;
`endif
                end
            end
            CHECK: begin
                if (resp_q == ACK_VAL) begin
                    done_nxt = 1'b1;
                end else begin
                    err_nxt      = 1'b1;
                    err_code_nxt = 2'b01;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Stale response: consume and drop it. Skip the cycle right after a
        // clear so a RemoteComm whose flag drops one cycle late sees only one.
        if (state != WAIT_RESP && resp_rdy && !clr_resp_rdy) begin
            clr_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cmd          <= '0;
            data         <= '0;
            tmo_cnt      <= '0;
            resp_q       <= '0;
            send_cmd     <= 1'b0;
            clr_resp_rdy <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= '0;
            last_cmd     <= '0;
`ifdef CMD_RETRY_EN
            retry_cnt    <= '0;
`endif
        end else begin
            state        <= state_nxt;
            send_cmd     <= send_nxt;
            clr_resp_rdy <= clr_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                cmd    <= fifo_cmd[rd_ptr[AW-1:0]];
                data   <= fifo_data[rd_ptr[AW-1:0]];
            end
            if (tmo_load) begin
                tmo_cnt <= (cmd == SET_CAL) ? CAL_LOAD : TMO_LOAD;
            end else if (state == WAIT_RESP && tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - TW'(1);
            end
            if (resp_cap) begin
                resp_q <= resp;
            end
            if (done_nxt || err_nxt) begin
                last_cmd <= cmd;
            end
            if (err_nxt) begin
                err_code <= err_code_nxt;
            end
`ifdef CMD_RETRY_EN
            if (pop) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_remote_cmd_seq.sv
// Directed bench for remote_cmd_seq. A behavioural RemoteComm stand-in
// answers send_cmd with cmd_sent two cycles later and, when enabled, with a
// response byte a programmable number of cycles after that.
module tb_remote_cmd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld = 1'b0;
    logic [7:0]  req_cmd = '0;
    logic [15:0] req_data = '0;
    logic        req_rdy;
    logic        send_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_sent = 1'b0;
    logic        resp_rdy = 1'b0;
    logic [7:0]  resp = '0;
    logic        clr_resp_rdy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  last_cmd;
    logic        busy;

    remote_cmd_seq #(
        .FIFO_DEPTH    (4),
        .TMO_CYCLES    (100),
        .CAL_TMO_CYCLES(1000),
        .MAX_RETRY     (3),
        .ACK_VAL       (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_cmd     (req_cmd),
        .req_data    (req_data),
        .req_rdy     (req_rdy),
        .send_cmd    (send_cmd),
        .cmd         (cmd),
        .data        (data),
        .cmd_sent    (cmd_sent),
        .resp_rdy    (resp_rdy),
        .resp        (resp),
        .clr_resp_rdy(clr_resp_rdy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .last_cmd    (last_cmd),
        .busy        (busy)
    );

    always #5 clk = ~clk;

`ifdef CMD_RETRY_EN
    localparam int EXP_TMO_SENDS = 4;
`else
    localparam int EXP_TMO_SENDS = 1;
`endif

    int checks = 0;
    int errors = 0;

    // Responder controls (written by the test sequence only)
    bit         rsp_auto   = 1'b1;
    int         rsp_delay  = 3;
    logic [7:0] bad_cmd    = 8'h00;
    int         manual_req = 0;

    // Monitor results (written by the responder/monitor process only)
    int          cyc = 0, n_sends = 0, n_done = 0, n_err = 0, n_clr = 0;
    int          t_sent = 0, t_err = 0;
    logic [23:0] send_log[$];
    logic [7:0]  done_cmd = '0, err_cmd = '0;
    logic [1:0]  err_cd = '0;

    // RemoteComm stand-in plus output monitor, sampled 1 time unit after each edge.
    initial begin : responder
        int sent_cd;
        int rsp_cd;
        int manual_seen;
        logic [7:0] cur_cmd;
        sent_cd = 0;
        rsp_cd = 0;
        manual_seen = 0;
        cur_cmd = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            cmd_sent = 1'b0;
            if (clr_resp_rdy) begin
                resp_rdy = 1'b0;
                n_clr++;
            end
            if (done) begin
                n_done++;
                done_cmd = last_cmd;
            end
            if (err) begin
                n_err++;
                err_cmd = last_cmd;
                err_cd  = err_code;
                t_err   = cyc;
            end
            if (rsp_cd > 0) begin
                rsp_cd--;
                if (rsp_cd == 0) begin
                    resp     = (cur_cmd == bad_cmd) ? 8'hFF : 8'hA5;
                    resp_rdy = 1'b1;
                end
            end
            if (send_cmd) begin
                n_sends++;
                send_log.push_back({cmd, data});
                cur_cmd = cmd;
                sent_cd = 2;
            end else if (sent_cd > 0) begin
                sent_cd--;
                if (sent_cd == 0) begin
                    cmd_sent = 1'b1;
                    t_sent   = cyc;
                    if (rsp_auto) rsp_cd = rsp_delay;
                end
            end
            if (manual_req != manual_seen) begin
                manual_seen = manual_req;
                resp        = 8'hA5;
                resp_rdy    = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish before", $time);
        $fatal(1);
    end

    task automatic push(input logic [7:0] c, input logic [15:0] d, input int budget,
                        output bit ok, output int waited);
        waited = 0;
        while (!req_rdy && waited < budget) begin
            @(posedge clk);
            #1;
            waited++;
        end
        ok = req_rdy;
        if (ok) begin
            req_vld  = 1'b1;
            req_cmd  = c;
            req_data = d;
            @(posedge clk);
            #1;
            req_vld = 1'b0;
        end
    endtask

    task automatic wait_finish(input int tgt, input int budget, output bit ok);
        int n = 0;
        while ((n_done + n_err) < tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = ((n_done + n_err) >= tgt);
    endtask

    task automatic wait_sends(input int tgt, input int budget, output bit ok);
        int n = 0;
        while (n_sends < tgt && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (n_sends >= tgt);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({send_cmd, clr_resp_rdy, done, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 0000", {send_cmd, clr_resp_rdy, done, err});
        end
        checks++;
        if ({req_rdy, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_rdy_busy: got %b expected 10", {req_rdy, busy});
        end
        checks++;
        if ({cmd, data, err_code, last_cmd} !== 34'h0) begin
            errors++;
            $display("FAIL reset_regs: got %h expected 0", {cmd, data, err_code, last_cmd});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_ack;
        int s0 = n_sends, d0 = n_done, e0 = n_err, c0 = n_clr, base = send_log.size();
        bit ok;
        int w;
        rsp_auto = 1'b1;
        rsp_delay = 3;
        push(8'h02, 16'h0001, 5, ok, w);
        // Push took effect at edge N; send_cmd must be high only after edge N+2.
        @(negedge clk);
        checks++;
        if ({send_cmd, busy} !== 2'b01) begin
            errors++;
            $display("FAIL lat_n: send_cmd,busy got %b expected 01", {send_cmd, busy});
        end
        @(negedge clk);
        checks++;
        if ({send_cmd, cmd, data} !== {1'b0, 8'h02, 16'h0001}) begin
            errors++;
            $display("FAIL lat_n1: got %h expected %h", {send_cmd, cmd, data}, {1'b0, 8'h02, 16'h0001});
        end
        @(negedge clk);
        checks++;
        if (send_cmd !== 1'b1) begin
            errors++;
            $display("FAIL lat_n2: send_cmd got %b expected 1", send_cmd);
        end
        @(negedge clk);
        checks++;
        if (send_cmd !== 1'b0) begin
            errors++;
            $display("FAIL lat_n3: send_cmd got %b expected 0", send_cmd);
        end
        wait_finish(d0 + e0 + 1, 50, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_wait: no done/err within 50 cycles, got %0d expected %0d", n_done + n_err, d0 + e0 + 1);
        end
        checks++;
        if (n_sends - s0 !== 1 || send_log.size() <= base) begin
            errors++;
            $display("FAIL single_sends: got %0d expected 1", n_sends - s0);
        end else if (send_log[base] !== 24'h020001) begin
            checks++;
            errors++;
            $display("FAIL single_payload: got %h expected 020001", send_log[base]);
        end
        checks++;
        if ({n_done - d0, n_err - e0, n_clr - c0} !== {32'd1, 32'd0, 32'd1}) begin
            errors++;
            $display("FAIL single_counts: done/err/clr got %0d/%0d/%0d expected 1/0/1", n_done - d0, n_err - e0, n_clr - c0);
        end
        checks++;
        if (done_cmd !== 8'h02) begin
            errors++;
            $display("FAIL single_last_cmd: got %h expected 02", done_cmd);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_fifo_full;
        logic [23:0] exp_log[6] = '{24'h02A001, 24'h03B002, 24'h04C003, 24'h05D004, 24'h07E005, 24'h08F006};
        int s0 = n_sends, d0 = n_done, e0 = n_err, base = send_log.size();
        bit ok;
        int w;
        rsp_auto = 1'b0;
        push(8'h02, 16'hA001, 5, ok, w);
        wait_sends(s0 + 1, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fifo_first_send: sends got %0d expected %0d", n_sends, s0 + 1);
        end
        // First command is now in flight and stalled; fill the FIFO behind it.
        push(8'h03, 16'hB002, 5, ok, w);
        push(8'h04, 16'hC003, 5, ok, w);
        push(8'h05, 16'hD004, 5, ok, w);
        push(8'h07, 16'hE005, 5, ok, w);
        @(negedge clk);
        checks++;
        if ({req_rdy, busy} !== 2'b01) begin
            errors++;
            $display("FAIL fifo_full_rdy: req_rdy,busy got %b expected 01", {req_rdy, busy});
        end
        rsp_auto = 1'b1;
        manual_req++;
        push(8'h08, 16'hF006, 20, ok, w);
        checks++;
        if (!ok || w < 1) begin
            errors++;
            $display("FAIL fifo_fifth_push: accepted %b after %0d waits, expected 1 after >=1", ok, w);
        end
        wait_finish(d0 + e0 + 6, 300, ok);
        checks++;
        if (n_done - d0 !== 6 || n_err - e0 !== 0) begin
            errors++;
            $display("FAIL fifo_done_count: done/err got %0d/%0d expected 6/0", n_done - d0, n_err - e0);
        end
        checks++;
        if (send_log.size() - base !== 6) begin
            errors++;
            $display("FAIL fifo_send_count: got %0d expected 6", send_log.size() - base);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (send_log[base + i] !== exp_log[i]) begin
                    errors++;
                    $display("FAIL fifo_order[%0d]: got %h expected %h", i, send_log[base + i], exp_log[i]);
                end
            end
        end
    endtask

    task automatic test_bad_resp;
        int d0 = n_done, e0 = n_err;
        bit ok;
        int w;
        rsp_auto = 1'b1;
        rsp_delay = 3;
        bad_cmd = 8'h04;
        push(8'h04, 16'h0123, 5, ok, w);
        push(8'h03, 16'h0456, 5, ok, w);
        wait_finish(d0 + e0 + 2, 100, ok);
        checks++;
        if (n_err - e0 !== 1 || n_done - d0 !== 1) begin
            errors++;
            $display("FAIL bad_counts: err/done got %0d/%0d expected 1/1", n_err - e0, n_done - d0);
        end
        checks++;
        if ({err_cd, err_cmd} !== {2'b01, 8'h04}) begin
            errors++;
            $display("FAIL bad_err_info: code,cmd got %b,%h expected 01,04", err_cd, err_cmd);
        end
        checks++;
        if (done_cmd !== 8'h03) begin
            errors++;
            $display("FAIL bad_next_done: last_cmd got %h expected 03", done_cmd);
        end
        bad_cmd = 8'h00;
    endtask

    task automatic test_timeout;
        int s0 = n_sends, d0 = n_done, e0 = n_err, base = send_log.size();
        bit ok;
        int w;
        rsp_auto = 1'b0;
        push(8'h03, 16'h0777, 5, ok, w);
        wait_finish(d0 + e0 + 1, 1000, ok);
        checks++;
        if (n_sends - s0 !== EXP_TMO_SENDS) begin
            errors++;
            $display("FAIL tmo_sends: got %0d expected %0d", n_sends - s0, EXP_TMO_SENDS);
        end
        checks++;
        if (n_err - e0 !== 1 || n_done - d0 !== 0) begin
            errors++;
            $display("FAIL tmo_counts: err/done got %0d/%0d expected 1/0", n_err - e0, n_done - d0);
        end
        checks++;
        if ({err_cd, err_cmd} !== {2'b10, 8'h03}) begin
            errors++;
            $display("FAIL tmo_err_info: code,cmd got %b,%h expected 10,03", err_cd, err_cmd);
        end
        // cmd_sent is driven one edge before the DUT samples it; 100 cycles of
        // timeout after that sampling edge gives a spacing of 101.
        checks++;
        if (t_err - t_sent !== 101) begin
            errors++;
            $display("FAIL tmo_latency: got %0d expected 101", t_err - t_sent);
        end
        checks++;
        if (send_log.size() <= base || send_log[send_log.size() - 1] !== 24'h030777) begin
            errors++;
            $display("FAIL tmo_resend_payload: got %h expected 030777",
                     (send_log.size() > base) ? send_log[send_log.size() - 1] : 24'hxxxxxx);
        end
        rsp_auto = 1'b1;
    endtask

    task automatic test_cal;
        int d0 = n_done, e0 = n_err;
        bit ok;
        int w;
        rsp_auto = 1'b1;
        rsp_delay = 500;
        push(8'h06, 16'h00C0, 5, ok, w);
        wait_finish(d0 + e0 + 1, 700, ok);
        checks++;
        if (n_done - d0 !== 1 || n_err - e0 !== 0) begin
            errors++;
            $display("FAIL cal_counts: done/err got %0d/%0d expected 1/0", n_done - d0, n_err - e0);
        end
        checks++;
        if (done_cmd !== 8'h06) begin
            errors++;
            $display("FAIL cal_last_cmd: got %h expected 06", done_cmd);
        end
        rsp_delay = 3;
    endtask

    task automatic test_reset_midflight;
        int s0, d0, e0, c0;
        bit ok;
        int w;
        rsp_auto = 1'b0;
        s0 = n_sends;
        push(8'h02, 16'h1357, 5, ok, w);
        wait_sends(s0 + 1, 20, ok);
        repeat (4) @(negedge clk);
        push(8'h03, 16'h2468, 5, ok, w);
        push(8'h04, 16'h3579, 5, ok, w);
        @(negedge clk);
        checks++;
        if ({busy, req_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL mid_pre_reset: busy,req_rdy got %b expected 11", {busy, req_rdy});
        end
        s0 = n_sends;
        d0 = n_done;
        e0 = n_err;
        c0 = n_clr;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({send_cmd, clr_resp_rdy, done, err, req_rdy, busy} !== 6'b000010) begin
            errors++;
            $display("FAIL mid_reset_ctrl: got %b expected 000010", {send_cmd, clr_resp_rdy, done, err, req_rdy, busy});
        end
        checks++;
        if ({cmd, data, err_code, last_cmd} !== 34'h0) begin
            errors++;
            $display("FAIL mid_reset_regs: got %h expected 0", {cmd, data, err_code, last_cmd});
        end
        manual_req++;
        repeat (8) @(negedge clk);
        checks++;
        if (n_clr - c0 !== 1) begin
            errors++;
            $display("FAIL mid_stale_clr: clr pulses got %0d expected 1", n_clr - c0);
        end
        checks++;
        if ({n_done - d0, n_err - e0, n_sends - s0} !== {32'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL mid_no_activity: done/err/sends got %0d/%0d/%0d expected 0/0/0", n_done - d0, n_err - e0, n_sends - s0);
        end
        checks++;
        if ({busy, resp_rdy} !== 2'b00) begin
            errors++;
            $display("FAIL mid_final_idle: busy,resp_rdy got %b expected 00", {busy, resp_rdy});
        end
        rsp_auto = 1'b1;
    endtask

    initial begin : main
        test_reset;
        test_single_ack;
        test_fifo_full;
        test_bad_resp;
        test_timeout;
        test_cal;
        test_reset_midflight;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
